// File: rtl/icu_pkg.sv
//------------------------------------------------------------------------------
// Module : icu_pkg
// Brief  : Shared ICU types and sizing constants for the program sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package icu_pkg;

  localparam int PC_W      = 8;
  localparam int RET_DEPTH = 4;
  localparam int DEPTH_W   = $clog2(RET_DEPTH + 1);

  typedef enum logic [3:0] {
    NOPO = 4'h0, LD   = 4'h1, LDC  = 4'h2, AND  = 4'h3,
    ANDC = 4'h4, OR   = 4'h5, ORC  = 4'h6, XNOR = 4'h7,
    STO  = 4'h8, STOC = 4'h9, IEN  = 4'hA, OEN  = 4'hB,
    JMP  = 4'hC, RTN  = 4'hD, SKZ  = 4'hE, NOPF = 4'hF
  } instruction_t;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/icu_ret_stack.sv
//------------------------------------------------------------------------------
// Module : icu_ret_stack
// Brief  : Fixed-depth return-address stack; push on full / pop on empty ignored.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module icu_ret_stack
  import icu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_addr,
  output logic            full,
  output logic            empty,
  output logic [PC_W-1:0] top
);

  localparam int IDX_W = $clog2(RET_DEPTH);

  logic [PC_W-1:0]    mem_q [RET_DEPTH];
  logic [PC_W-1:0]    mem_d [RET_DEPTH];
  logic [DEPTH_W-1:0] count_q, count_d;
  logic [IDX_W-1:0]   push_idx, top_idx;

  assign full     = (count_q == DEPTH_W'(RET_DEPTH));
  assign empty    = (count_q == '0);
  assign push_idx = count_q[IDX_W-1:0];
  assign top_idx  = push_idx - IDX_W'(1);
  assign top      = mem_q[top_idx];

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (push && !full) begin
      mem_d[push_idx] = push_addr;
      count_d         = count_q + DEPTH_W'(1);
    end else if (pop && !empty) begin
      count_d = count_q - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int k = 0; k < RET_DEPTH; k++) mem_q[k] <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/icu_sequencer.sv
//------------------------------------------------------------------------------
// Module : icu_sequencer
// Brief  : Program counter, RUN/HALT control, call/return and output latches.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module icu_sequencer
  import icu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   prog_addr,
  input  logic [11:0]       prog_data,
  output instruction_t      i,
  output logic              data_in,
  input  logic [7:0]        in_port,
  input  logic              write,
  input  logic              data_out,
  input  logic              jmp,
  input  logic              rtn,
  input  logic              flag_o,
  input  logic              flag_f,
  input  logic              run,
  output logic [7:0]        out_port,
  output logic              halted,
  output logic              stack_err
);

  logic [0:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [7:0]      out_q, out_d;
  logic            call_pend_q, call_pend_d;
  logic            err_q, err_d;
  logic            push, pop, stk_full, stk_empty;
  logic [PC_W-1:0] stk_top;

  assign pc_inc    = pc_q + PC_W'(1);
  assign i         = instruction_t'(prog_data[11:8]);
  assign data_in   = in_port[prog_data[2:0]];
  assign prog_addr = pc_q;
  assign out_port  = out_q;
  assign stack_err = err_q;

  icu_ret_stack u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (pc_inc),
    .full      (stk_full),
    .empty     (stk_empty),
    .top       (stk_top)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (!rtn && !jmp && flag_o) state_d = ST_HALT;
    end else if (run) begin
      state_d = ST_RUN;
    end
  end

  always_comb begin
    halted = (state_q == ST_HALT);
  end

  // PC priority in RUN: rtn > jmp > flag_o > increment
  always_comb begin
    pc_d        = pc_q;
    out_d       = out_q;
    call_pend_d = call_pend_q;
    err_d       = err_q;
    push        = 1'b0;
    pop         = 1'b0;
    if (state_q == ST_RUN) begin
      call_pend_d = flag_f;
      if (write) out_d[prog_data[2:0]] = data_out;
      if (rtn) begin
        if (stk_empty) begin
          pc_d  = '0;
          err_d = 1'b1;
        end else begin
          pc_d = stk_top;
          pop  = 1'b1;
        end
      end else if (jmp) begin
        pc_d = prog_data[7:0];
        if (call_pend_q) begin
          if (stk_full) err_d = 1'b1;
          else          push  = 1'b1;
        end
      end else if (!flag_o) begin
        pc_d = pc_inc;
      end
    end else if (run) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      out_q       <= '0;
      call_pend_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      out_q       <= out_d;
      call_pend_q <= call_pend_d;
      err_q       <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icu_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_icu_sequencer
// Brief  : Directed self-checking bench; the bench plays program memory and ICU decode.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_icu_sequencer;
  import icu_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   prog_addr;
  logic [11:0]  prog_data;
  instruction_t i;
  logic         data_in;
  logic [7:0]   in_port = 8'h08;
  logic         write, data_out, jmp, rtn, flag_o, flag_f;
  logic         run = 1'b0;
  logic         wr_force = 1'b0;
  logic [7:0]   out_port;
  logic         halted, stack_err;

  logic [11:0]  mem [256];
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  assign prog_data = mem[prog_addr];
  assign jmp       = (prog_data[11:8] == 4'hC);
  assign rtn       = (prog_data[11:8] == 4'hD);
  assign flag_o    = (prog_data[11:8] == 4'h0);
  assign flag_f    = (prog_data[11:8] == 4'hF);
  assign write     = (prog_data[11:8] == 4'h8) || wr_force;
  assign data_out  = 1'b1;

  icu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .i         (i),
    .data_in   (data_in),
    .in_port   (in_port),
    .write     (write),
    .data_out  (data_out),
    .jmp       (jmp),
    .rtn       (rtn),
    .flag_o    (flag_o),
    .flag_f    (flag_f),
    .run       (run),
    .out_port  (out_port),
    .halted    (halted),
    .stack_err (stack_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic fill_ien();
    for (int k = 0; k < 256; k++) mem[k] = 12'hA00;
  endtask

  // Asserted at a negedge so the reset values are seen before any clock edge
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_pc",     32'(prog_addr), 32'h00);
    check("rst_halted", 32'(halted),    32'h0);
    check("rst_out",    32'(out_port),  32'h00);
    check("rst_err",    32'(stack_err), 32'h0);
    check("rst_depth",  32'(dut.u_ret_stack.count_q), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to(input logic [7:0] target);
    int n = 0;
    while (prog_addr != target && n < 300) begin
      step();
      n++;
    end
    check("run_to", 32'(prog_addr), 32'(target));
  endtask

  initial begin
    fill_ien();
    mem[2] = 12'h103;
    mem[3] = 12'h805;
    do_reset();

    for (int k = 1; k <= 4; k++) begin
      if (k == 3) begin
        check("ld_opcode",  32'(i),       32'(LD));
        check("ld_data_in", 32'(data_in), 32'h1);
      end
      step();
      check("seq_pc", 32'(prog_addr), 32'(k));
    end
    check("sto_out", 32'(out_port), 32'h20);

    // Plain jump: no call pending, no push
    mem[8'h10] = 12'hC40;
    run_to(8'h10);
    step();
    check("jmp_pc",    32'(prog_addr), 32'h40);
    check("jmp_depth", 32'(dut.u_ret_stack.count_q), 32'h0);

    // Single call/return
    fill_ien();
    mem[8'h10] = 12'hF00;
    mem[8'h11] = 12'hC80;
    mem[8'h80] = 12'hD00;
    do_reset();
    run_to(8'h10);
    step(); check("call_nopf", 32'(prog_addr), 32'h11);
    step(); check("call_pc",   32'(prog_addr), 32'h80);
    check("call_depth", 32'(dut.u_ret_stack.count_q), 32'h1);
    step(); check("ret_pc",    32'(prog_addr), 32'h12);
    check("ret_depth", 32'(dut.u_ret_stack.count_q), 32'h0);
    check("ret_err",   32'(stack_err), 32'h0);

    // Five nested calls, then five returns
    fill_ien();
    for (int k = 0; k < 5; k++) begin
      mem[8'(k * 16)]     = 12'hF00;
      mem[8'(k * 16 + 1)] = 12'hC00 | 12'((k + 1) * 16);
    end
    mem[8'h50] = 12'hD00;
    mem[8'h32] = 12'hD00;
    mem[8'h22] = 12'hD00;
    mem[8'h12] = 12'hD00;
    mem[8'h02] = 12'hD00;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(); step();
      check("nest_pc", 32'(prog_addr), 32'((k + 1) * 16));
    end
    check("nest_err",   32'(stack_err), 32'h1);
    check("nest_depth", 32'(dut.u_ret_stack.count_q), 32'h4);
    step(); check("ret1", 32'(prog_addr), 32'h32);
    step(); check("ret2", 32'(prog_addr), 32'h22);
    step(); check("ret3", 32'(prog_addr), 32'h12);
    step(); check("ret4", 32'(prog_addr), 32'h02);
    step(); check("ret5", 32'(prog_addr), 32'h00);
    check("ret5_err", 32'(stack_err), 32'h1);

    // Halt, ignored writes, resume
    fill_ien();
    mem[8'h20] = 12'h007;
    do_reset();
    run_to(8'h20);
    check("pre_halt", 32'(halted), 32'h0);
    step();
    wr_force = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("halt_flag", 32'(halted),    32'h1);
      check("halt_pc",   32'(prog_addr), 32'h20);
      step();
    end
    check("halt_out", 32'(out_port), 32'h00);
    wr_force = 1'b0;
    run = 1'b1;
    step();
    run = 1'b0;
    check("resume_pc",     32'(prog_addr), 32'h21);
    check("resume_halted", 32'(halted),    32'h0);

    // PC wrap
    fill_ien();
    do_reset();
    run_to(8'hFF);
    step();
    check("wrap_pc", 32'(prog_addr), 32'h00);

    // Async reset while halted with live stack and outputs
    fill_ien();
    mem[8'h01] = 12'h800;
    mem[8'h02] = 12'hF00;
    mem[8'h03] = 12'hC05;
    mem[8'h05] = 12'h000;
    do_reset();
    run_to(8'h05);
    step();
    check("pre_rst_halted", 32'(halted),   32'h1);
    check("pre_rst_out",    32'(out_port), 32'h01);
    check("pre_rst_depth",  32'(dut.u_ret_stack.count_q), 32'h1);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
